// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Shift register carrying {valid, port} tags alongside reads in flight.
// Latency: DEPTH cycles from tag_in to tag_out.
// Backpressure: none; advances every cycle, synchronous reset clears all stages.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto a single-port memory; round-robin, or fixed priority with MEM_ARB_FIXED_PRIO_EN.
// Latency: grant is combinational, read data returns READ_LATENCY+1 cycles after the grant.
// Backpressure: a losing requester holds req/addr/data/wren until granted; returns are never stalled.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              p0_req,
  input  logic              p0_wren,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_gnt,
  output logic              p0_valid,
  output logic [DATA_W-1:0] p0_q,

  input  logic              p1_req,
  input  logic              p1_wren,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_gnt,
  output logic              p1_valid,
  output logic [DATA_W-1:0] p1_q,

  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_wren,
  input  logic [DATA_W-1:0] m_q
);

  localparam int TAG_DEPTH = READ_LATENCY + 1;

  logic              any_gnt;
  logic              sel_port;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  tag_t              tag_in;
  tag_t              tag_out;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      p0_gnt = p0_req;
      p1_gnt = p1_req & ~p0_req;
    end
  end
`else
  // last holds the most recently granted port; a tie goes to the other one.
  logic last;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        if (last == PORT_IO) begin
          p0_gnt = 1'b1;
        end else begin
          p1_gnt = 1'b1;
        end
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= PORT_IO;
    end else if (p0_gnt) begin
      last <= PORT_CPU;
    end else if (p1_gnt) begin
      last <= PORT_IO;
    end
  end
`endif

  assign any_gnt  = p0_gnt | p1_gnt;
  assign sel_port = p1_gnt ? PORT_IO : PORT_CPU;
  assign sel_wren = p1_gnt ? p1_wren : p0_wren;
  assign sel_addr = p1_gnt ? p1_addr : p0_addr;
  assign sel_data = p1_gnt ? p1_data : p0_data;

  // Address/data hold across idle cycles; only the write strobe drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      m_addr <= '0;
      m_data <= '0;
      m_wren <= 1'b0;
    end else if (any_gnt) begin
      m_addr <= sel_addr;
      m_data <= sel_data;
      m_wren <= sel_wren;
    end else begin
      m_wren <= 1'b0;
    end
  end

  assign tag_in.valid = any_gnt & ~sel_wren;
  assign tag_in.port  = sel_port;

  mem_arb_tag_pipe #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign p0_valid = tag_out.valid && (tag_out.port == PORT_CPU);
  assign p1_valid = tag_out.valid && (tag_out.port == PORT_IO);
  assign p0_q     = m_q;
  assign p1_q     = m_q;

  a_gnt_onehot: assert property (@(posedge clock) !(p0_gnt && p1_gnt));
  a_gnt_has_req: assert property (@(posedge clock) (!p0_gnt || p0_req) && (!p1_gnt || p1_req));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4K x 16 memory model and per-port read scoreboards.
module tb_mem_port_arbiter;

  localparam int RL = 1;

  typedef struct {
    logic [15:0] dat;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_wren, p1_req, p1_wren;
  logic [11:0] p0_addr, p1_addr;
  logic [15:0] p0_data, p1_data;
  logic        p0_gnt, p0_valid, p1_gnt, p1_valid;
  logic [15:0] p0_q, p1_q;
  logic [11:0] m_addr;
  logic [15:0] m_data;
  logic        m_wren;
  logic [15:0] m_q;

  logic        mem_init;
  logic [15:0] mem     [4096];
  logic [15:0] ref_mem [4096];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  mem_port_arbiter #(
    .ADDR_W       (12),
    .DATA_W       (16),
    .READ_LATENCY (RL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_wren  (p0_wren),
    .p0_addr  (p0_addr),
    .p0_data  (p0_data),
    .p0_gnt   (p0_gnt),
    .p0_valid (p0_valid),
    .p0_q     (p0_q),
    .p1_req   (p1_req),
    .p1_wren  (p1_wren),
    .p1_addr  (p1_addr),
    .p1_data  (p1_data),
    .p1_gnt   (p1_gnt),
    .p1_valid (p1_valid),
    .p1_q     (p1_q),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_wren   (m_wren),
    .m_q      (m_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010) return 16'h1234;
    return {4'hA, a};
  endfunction

  // Memory macro: registered address, q valid the cycle after m_addr is sampled.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
    end else begin
      m_q <= mem[m_addr];
      if (m_wren) mem[m_addr] <= m_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    forever begin
      @(negedge clock);
      if (p0_gnt || p1_gnt) begin
        chk("gnt_onehot", 32'(p0_gnt & p1_gnt), 0);
        chk("gnt_without_req", 32'((p0_gnt & ~p0_req) | (p1_gnt & ~p1_req)), 0);
      end
      if (p0_valid) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL p0_unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("p0_read_data", 32'(p0_q), 32'(e.dat));
          chk("p0_read_cycle", cyc, e.due);
        end
      end
      if (p1_valid) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL p1_unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("p1_read_data", 32'(p1_q), 32'(e.dat));
          chk("p1_read_cycle", cyc, e.due);
        end
      end
      if (p0_gnt) begin
        if (p0_wren) ref_mem[p0_addr] = p0_data;
        else q0.push_back('{dat: ref_mem[p0_addr], due: cyc + 1 + RL});
      end
      if (p1_gnt) begin
        if (p1_wren) ref_mem[p1_addr] = p1_data;
        else q1.push_back('{dat: ref_mem[p1_addr], due: cyc + 1 + RL});
      end
      if (reset) begin
        q0.delete();
        q1.delete();
      end
    end
  endtask

  initial begin
    int wcount;
    logic [3:0] exp0;
    logic [3:0] exp1;

    reset = 1'b1; mem_init = 1'b1;
    p0_req = 0; p0_wren = 0; p0_addr = '0; p0_data = '0;
    p1_req = 0; p1_wren = 0; p1_addr = '0; p1_data = '0;
    fork monitor(); join_none

    // Reset state, with a request held to show grants are masked.
    next_cycle();
    mem_init = 1'b0;
    p0_req = 1'b1;
    @(negedge clock);
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_m_addr", 32'(m_addr), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_wren", 32'(m_wren), 0);
    chk("rst_valid", 32'({p0_valid, p1_valid}), 0);
    next_cycle();
    reset = 1'b0; p0_req = 1'b0;

    // Single read of 0x010.
    p0_req = 1; p0_wren = 0; p0_addr = 12'h010;
    @(negedge clock);
    chk("rd_p0_gnt", 32'(p0_gnt), 1);
    chk("rd_p1_gnt", 32'(p1_gnt), 0);
    next_cycle();
    p0_req = 0;
    @(negedge clock);
    chk("rd_m_addr", 32'(m_addr), 32'h010);
    chk("rd_m_wren", 32'(m_wren), 0);
    next_cycle();
    @(negedge clock);
    chk("rd_p0_valid", 32'(p0_valid), 1);
    chk("rd_p0_q", 32'(p0_q), 32'h1234);
    chk("rd_p1_valid", 32'(p1_valid), 0);
    next_cycle();

    // p1 writes 0xBEEF to 0x0FF, then p0 reads it back.
    wcount = 0;
    p1_req = 1; p1_wren = 1; p1_addr = 12'h0FF; p1_data = 16'hBEEF;
    @(negedge clock);
    chk("wr_p1_gnt", 32'(p1_gnt), 1);
    wcount += int'(m_wren);
    next_cycle();
    p1_req = 0; p1_wren = 0;
    p0_req = 1; p0_wren = 0; p0_addr = 12'h0FF;
    @(negedge clock);
    chk("wr_rd_p0_gnt", 32'(p0_gnt), 1);
    chk("wr_m_addr", 32'(m_addr), 32'h0FF);
    chk("wr_m_data", 32'(m_data), 32'hBEEF);
    wcount += int'(m_wren);
    next_cycle();
    p0_req = 0;
    @(negedge clock);
    wcount += int'(m_wren);
    next_cycle();
    @(negedge clock);
    wcount += int'(m_wren);
    chk("wr_wren_pulses", 32'(wcount), 1);
    chk("wr_rd_valid", 32'(p0_valid), 1);
    chk("wr_rd_q", 32'(p0_q), 32'hBEEF);
    next_cycle();

    // Streaming reads 0x000..0x007.
    for (int i = 0; i < 10; i++) begin
      p0_req = (i < 8); p0_wren = 0; p0_addr = 12'(i);
      @(negedge clock);
      chk("stream_gnt", 32'(p0_gnt), 32'(i < 8));
      chk("stream_valid", 32'(p0_valid), 32'(i >= 2));
      next_cycle();
    end
    p0_req = 0;

    // Idle: address holds at the last streamed read.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle_m_wren", 32'(m_wren), 0);
      chk("idle_m_addr", 32'(m_addr), 32'h007);
      chk("idle_gnt", 32'({p0_gnt, p1_gnt}), 0);
      chk("idle_valid", 32'({p0_valid, p1_valid}), 0);
      next_cycle();
    end

    // Reset the cycle after a granted read: the return must vanish.
    p0_req = 1; p0_wren = 0; p0_addr = 12'h005; p0_data = 16'h5A5A;
    @(negedge clock);
    chk("rstmid_gnt", 32'(p0_gnt), 1);
    next_cycle();
    p0_req = 0; reset = 1;
    @(negedge clock);
    chk("rstmid_gnt_masked", 32'(p0_gnt | p1_gnt), 0);
    next_cycle();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rstmid_no_valid", 32'(p0_valid), 0);
      if (i == 0) begin
        chk("rstmid_m_addr", 32'(m_addr), 0);
        chk("rstmid_m_data", 32'(m_data), 0);
        chk("rstmid_m_wren", 32'(m_wren), 0);
      end
      next_cycle();
    end

    // Contention right after reset.
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp0 = 4'b1111; exp1 = 4'b0000;
`else
    exp0 = 4'b0101; exp1 = 4'b1010;
`endif
    p0_req = 1; p0_wren = 0; p0_addr = 12'h020;
    p1_req = 1; p1_wren = 0; p1_addr = 12'h030;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("tie_p0_gnt", 32'(p0_gnt), 32'(exp0[i]));
      chk("tie_p1_gnt", 32'(p1_gnt), 32'(exp1[i]));
      next_cycle();
    end
    p0_req = 0; p1_req = 0;
    for (int i = 0; i < 3; i++) next_cycle();

    @(negedge clock);
    chk("drain_q0_empty", 32'(q0.size()), 0);
    chk("drain_q1_empty", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
